// File: rtl/nibbler_run_ctrl_if.sv
// Control/status bundle between the Nibbler core environment and the
// run/halt/step controller.
//
// Handshake: there is no valid/ready pair here. Every input is sampled on
// each rising clk edge. The request inputs (run_req, halt_req, step_req)
// are levels, and the controller samples them only in the states where
// they matter. cpu_en is combinational from the controller state and the
// current inputs, so the core acts on it in the same cycle.
interface nibbler_run_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc_addr;
  logic              phase;
  logic              cpu_en;
  logic              halted;
  logic              bp_hit;
  logic [CNT_W-1:0]  instr_count;
  logic [1:0]        state_dbg;

  // Environment / core side: drives requests and core status
  modport master (
    output run_req, halt_req, step_req, bp_en, bp_addr, pc_addr, phase,
    input  cpu_en, halted, bp_hit, instr_count, state_dbg
  );

  // Controller side
  modport slave (
    input  run_req, halt_req, step_req, bp_en, bp_addr, pc_addr, phase,
    output cpu_en, halted, bp_hit, instr_count, state_dbg
  );
endinterface

// File: rtl/nibbler_run_ctrl.sv
// Run/halt/single-step controller for the Nibbler core. It produces the
// core clock-enable and stops only at instruction boundaries (phase==0).
// It also provides an address breakpoint and a retired-instruction counter.
module nibbler_run_ctrl #(
  parameter int ADDR_W        = 12,
  parameter int CNT_W         = 16,
  parameter int START_RUNNING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  nibbler_run_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (START_RUNNING != 0) ? S_RUN : S_HALT;

  state_t           state_q, state_d;
  logic             halt_pend_q, halt_pend_d;
  logic             skip_bp_q, skip_bp_d;
  logic             step_cnt_q, step_cnt_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic bp_cond;
  logic stop;
  logic cpu_en;
  logic retire;

  // Breakpoint/stop decode and the core clock-enable
  always_comb begin
    bp_cond = bus.bp_en & ~bus.phase & (bus.pc_addr == bus.bp_addr) & ~skip_bp_q;
    stop    = ~bus.phase & (bus.halt_req | halt_pend_q | bp_cond);
    cpu_en  = 1'b0;
    case (state_q)
      S_RUN:   cpu_en = ~stop;
      S_HALT:  cpu_en = 1'b0;
      S_STEP:  cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
    // The core never advances while the controller is held in reset
    cpu_en = cpu_en & ~reset;
    retire = cpu_en & bus.phase;
  end

  // Next-state logic for the FSM and its side registers
  always_comb begin
    state_d       = state_q;
    halt_pend_d   = halt_pend_q;
    skip_bp_d     = skip_bp_q;
    step_cnt_d    = step_cnt_q;
    bp_hit_d      = bp_hit_q;
    instr_count_d = instr_count_q;

    case (state_q)
      S_RUN: begin
        if (stop) begin
          state_d     = S_HALT;
          halt_pend_d = 1'b0;
          // Attribute the stop to the breakpoint only if no halt request
          // was also responsible
          bp_hit_d    = bp_cond & ~(bus.halt_req | halt_pend_q);
        end else if (bus.halt_req & bus.phase) begin
          // Let the execute cycle finish and stop at the next boundary
          halt_pend_d = 1'b1;
        end
      end
      S_HALT: begin
        if (bus.step_req & ~bus.halt_req) begin
          state_d    = S_STEP;
          step_cnt_d = 1'b0;
          bp_hit_d   = 1'b0;
          skip_bp_d  = 1'b1;
        end else if (bus.run_req & ~bus.halt_req) begin
          state_d   = S_RUN;
          bp_hit_d  = 1'b0;
          skip_bp_d = 1'b1;
        end
      end
      S_STEP: begin
        if (step_cnt_q) begin
          state_d    = S_HALT;
          step_cnt_d = 1'b0;
        end else begin
          step_cnt_d = 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    // The resume instruction has executed, so re-arm the breakpoint.
    // These two conditions never overlap: HALT exits happen with cpu_en=0.
    if (retire) begin
      skip_bp_d     = 1'b0;
      instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State and side registers, asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RESET_STATE;
      halt_pend_q   <= 1'b0;
      skip_bp_q     <= 1'b0;
      step_cnt_q    <= 1'b0;
      bp_hit_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      halt_pend_q   <= halt_pend_d;
      skip_bp_q     <= skip_bp_d;
      step_cnt_q    <= step_cnt_d;
      bp_hit_q      <= bp_hit_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.cpu_en      = cpu_en;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.bp_hit      = bp_hit_q;
  assign bus.instr_count = instr_count_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_nibbler_run_ctrl.sv
// Bench for nibbler_run_ctrl. A small core model (PC/PHASE advancing on
// cpu_en) closes the loop. A second instance with a 4-bit counter shares
// the same inputs so that counter wrap can be observed.
module tb_nibbler_run_ctrl;

  logic clk;
  logic reset;

  nibbler_run_ctrl_if #(.ADDR_W(12), .CNT_W(16)) if16 ();
  nibbler_run_ctrl_if #(.ADDR_W(12), .CNT_W(4))  if4 ();

  nibbler_run_ctrl #(.ADDR_W(12), .CNT_W(16), .START_RUNNING(1)) dut (
    .clk(clk), .reset(reset), .bus(if16.slave)
  );

  nibbler_run_ctrl #(.ADDR_W(12), .CNT_W(4), .START_RUNNING(1)) dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt;
  int exp_pc;

  logic [11:0] core_pc;
  logic        core_phase;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Minimal core model: fetch/execute alternate, and the PC advances after execute
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_pc    <= '0;
      core_phase <= 1'b0;
    end else if (if16.cpu_en) begin
      core_phase <= ~core_phase;
      if (core_phase) core_pc <= core_pc + 12'd1;
    end
  end

  assign if16.pc_addr  = core_pc;
  assign if16.phase    = core_phase;
  assign if4.pc_addr   = core_pc;
  assign if4.phase     = core_phase;
  assign if4.run_req   = if16.run_req;
  assign if4.halt_req  = if16.halt_req;
  assign if4.step_req  = if16.step_req;
  assign if4.bp_en     = if16.bp_en;
  assign if4.bp_addr   = if16.bp_addr;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_reqs();
    if16.run_req  = 1'b0;
    if16.halt_req = 1'b0;
    if16.step_req = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    if16.bp_en   = 1'b0;
    if16.bp_addr = '0;
    reset = 1'b1;
    #3;
    n_tests++;
    if (if16.cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en got=%0b exp=0", if16.cpu_en); end
    n_tests++;
    if (if16.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%0b exp=0", if16.halted); end
    n_tests++;
    if (if16.instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", if16.instr_count); end
    n_tests++;
    if (if16.bp_hit !== 1'b0) begin n_fail++; $display("FAIL reset_bp_hit got=%0b exp=0", if16.bp_hit); end
    do_reset();
  endtask

  task automatic test_free_run();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if16.cpu_en !== 1'b1) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL free_run_cpu_en low_cycles=%0d exp=0", bad); end
    n_tests++;
    if (if16.instr_count !== 16'd10) begin n_fail++; $display("FAIL free_run_count got=%0d exp=10", if16.instr_count); end
    n_tests++;
    if (if16.halted !== 1'b0) begin n_fail++; $display("FAIL free_run_halted got=%0b exp=0", if16.halted); end
  endtask

  task automatic test_halt_phase1();
    tick();                       // fetch cycle passes, now in an execute cycle
    if16.halt_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if (if16.cpu_en !== 1'b1 || if16.phase !== 1'b1) begin
      n_fail++; $display("FAIL halt_exec_completes cpu_en=%0b phase=%0b exp=1/1", if16.cpu_en, if16.phase);
    end
    tick();
    if16.halt_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if16.cpu_en !== 1'b0) begin n_fail++; $display("FAIL halt_boundary_cpu_en got=%0b exp=0", if16.cpu_en); end
    tick();
    n_tests++;
    if (if16.halted !== 1'b1 || if16.bp_hit !== 1'b0) begin
      n_fail++; $display("FAIL halt_status halted=%0b bp_hit=%0b exp=1/0", if16.halted, if16.bp_hit);
    end
    repeat (5) tick();
    n_tests++;
    if (if16.instr_count !== 16'd11 || if16.cpu_en !== 1'b0) begin
      n_fail++; $display("FAIL halt_frozen count=%0d cpu_en=%0b exp=11/0", if16.instr_count, if16.cpu_en);
    end
  endtask

  task automatic test_breakpoint();
    int waited = 0;
    if16.bp_en   = 1'b1;
    if16.bp_addr = 12'h005;
    do_reset();
    while (if16.halted !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    n_tests++;
    if (waited >= 40) begin n_fail++; $display("FAIL bp_timeout waited=%0d exp<40", waited); end
    n_tests++;
    if (if16.pc_addr !== 12'h005 || if16.cpu_en !== 1'b0 || if16.bp_hit !== 1'b1) begin
      n_fail++; $display("FAIL bp_stop pc=%0h cpu_en=%0b bp_hit=%0b exp=005/0/1", if16.pc_addr, if16.cpu_en, if16.bp_hit);
    end
    n_tests++;
    if (if16.instr_count !== 16'd5) begin n_fail++; $display("FAIL bp_count got=%0d exp=5", if16.instr_count); end
    if16.run_req = 1'b1;
    tick();
    if16.run_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if16.cpu_en !== 1'b1 || if16.bp_hit !== 1'b0) begin
      n_fail++; $display("FAIL bp_resume cpu_en=%0b bp_hit=%0b exp=1/0", if16.cpu_en, if16.bp_hit);
    end
    tick();
    tick();
    n_tests++;
    if (if16.instr_count !== 16'd6 || if16.pc_addr !== 12'h006) begin
      n_fail++; $display("FAIL bp_resume_exec count=%0d pc=%0h exp=6/006", if16.instr_count, if16.pc_addr);
    end
    if16.halt_req = 1'b1;
    tick();
    if16.halt_req = 1'b0;
    n_tests++;
    if (if16.halted !== 1'b1 || if16.bp_hit !== 1'b0 || if16.instr_count !== 16'd6) begin
      n_fail++; $display("FAIL bp_then_halt halted=%0b bp_hit=%0b count=%0d exp=1/0/6", if16.halted, if16.bp_hit, if16.instr_count);
    end
  endtask

  task automatic test_step();
    int en_cycles = 0;
    if16.step_req = 1'b1;
    tick();
    if16.step_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if16.cpu_en === 1'b1) en_cycles++;
      tick();
    end
    n_tests++;
    if (en_cycles != 2) begin n_fail++; $display("FAIL step_single en_cycles=%0d exp=2", en_cycles); end
    n_tests++;
    if (if16.instr_count !== 16'd7 || if16.halted !== 1'b1) begin
      n_fail++; $display("FAIL step_single_state count=%0d halted=%0b exp=7/1", if16.instr_count, if16.halted);
    end
    en_cycles = 0;
    if16.step_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (if16.cpu_en === 1'b1) en_cycles++;
      tick();
    end
    if16.step_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if16.cpu_en === 1'b1) en_cycles++;
      tick();
    end
    n_tests++;
    if (en_cycles != 6 || if16.instr_count !== 16'd10 || if16.halted !== 1'b1) begin
      n_fail++; $display("FAIL step_held en_cycles=%0d count=%0d halted=%0b exp=6/10/1", en_cycles, if16.instr_count, if16.halted);
    end
  endtask

  task automatic test_conflicts();
    int en_cycles = 0;
    if16.halt_req = 1'b1;
    if16.run_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if16.cpu_en === 1'b1) en_cycles++;
      tick();
    end
    n_tests++;
    if (if16.halted !== 1'b1 || en_cycles != 0) begin
      n_fail++; $display("FAIL halt_over_run halted=%0b en_cycles=%0d exp=1/0", if16.halted, en_cycles);
    end
    if16.run_req  = 1'b0;
    if16.step_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if16.cpu_en === 1'b1) en_cycles++;
      tick();
    end
    clear_reqs();
    n_tests++;
    if (if16.halted !== 1'b1 || en_cycles != 0 || if16.instr_count !== 16'd10) begin
      n_fail++; $display("FAIL halt_over_step halted=%0b en_cycles=%0d count=%0d exp=1/0/10", if16.halted, en_cycles, if16.instr_count);
    end
  endtask

  task automatic test_reset_mid_step();
    if16.step_req = 1'b1;
    tick();
    if16.step_req = 1'b0;
    #2;
    n_tests++;
    if (if16.cpu_en !== 1'b1) begin n_fail++; $display("FAIL pre_reset_step cpu_en=%0b exp=1", if16.cpu_en); end
    reset = 1'b1;
    #1;
    n_tests++;
    if (if16.cpu_en !== 1'b0 || if16.instr_count !== 16'd0 || if16.bp_hit !== 1'b0 || if16.halted !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_step cpu_en=%0b count=%0d bp_hit=%0b halted=%0b exp=0/0/0/0",
                         if16.cpu_en, if16.instr_count, if16.bp_hit, if16.halted);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    if16.bp_en = 1'b0;
    do_reset();
    repeat (32) tick();
    n_tests++;
    if (if4.instr_count !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt4 got=%0d exp=0", if4.instr_count); end
    n_tests++;
    if (if16.instr_count !== 16'd16) begin n_fail++; $display("FAIL wrap_cnt16 got=%0d exp=16", if16.instr_count); end
  endtask

  // Randomized operations from HALT, checked against arithmetic expectations
  task automatic test_random();
    int m, j, r, ret;
    logic exp_bp;
    if16.bp_en    = 1'b1;
    if16.bp_addr  = 12'hfff;
    if16.halt_req = 1'b1;         // stop at the very first boundary
    do_reset();
    tick();
    if16.halt_req = 1'b0;
    exp_cnt = 0;
    exp_pc  = 0;
    for (int op = 0; op < 30; op++) begin
      if ($urandom_range(0, 2) == 0) begin
        if16.step_req = 1'b1;
        tick();
        if16.step_req = 1'b0;
        repeat (3) tick();
        exp_cnt++;
        exp_pc++;
        exp_bp = 1'b0;
      end else begin
        m = $urandom_range(0, 20);
        j = $urandom_range(0, 8);
        if16.bp_addr = 12'(exp_pc + j);
        r = (m + 1) / 2;
        if (j > 0 && j < r) begin
          ret = j;
          exp_bp = 1'b1;
        end else begin
          ret = r;
          exp_bp = 1'b0;
        end
        if16.run_req = 1'b1;
        tick();
        if16.run_req = 1'b0;
        repeat (m) tick();
        if16.halt_req = 1'b1;
        tick();
        if16.halt_req = 1'b0;
        repeat (3) tick();
        exp_cnt += ret;
        exp_pc  += ret;
      end
      n_tests++;
      if (if16.halted !== 1'b1 || if16.instr_count !== 16'(exp_cnt) || if16.bp_hit !== exp_bp
          || if16.pc_addr !== 12'(exp_pc) || if4.instr_count !== 4'(exp_cnt)) begin
        n_fail++;
        $display("FAIL random_op%0d halted=%0b count=%0d cnt4=%0d bp_hit=%0b pc=%0d exp=1/%0d/%0d/%0b/%0d",
                 op, if16.halted, if16.instr_count, if4.instr_count, if16.bp_hit, if16.pc_addr,
                 exp_cnt, exp_cnt % 16, exp_bp, exp_pc);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    if16.bp_en   = 1'b0;
    if16.bp_addr = '0;
    test_reset();
    test_free_run();
    test_halt_phase1();
    test_breakpoint();
    test_step();
    test_conflicts();
    test_reset_mid_step();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
